stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Sequencing controller for the two-digit BCD seconds counter (BCD1 tens, BCD0 units).
- Generates the counter's Enable from a clock prescaler.
- Decodes Start/Stop, Lap and Clear keys through a run-state FSM.
- Drives the counter's active-high clear and muxes live or lap-frozen digits to the display path.

Parameters:
TICK_DIV, 50000000, Clock cycles per count tick (1 Hz at 50 MHz); legal range >= 2.
TICK_W, 26, Prescaler width; must satisfy 2^TICK_W >= TICK_DIV.

Ports:
Clock  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low; Reset=0 at a rising edge resets the block
KeyStart  in  1  debounced level, start/stop toggle
KeyLap  in  1  debounced level, lap freeze/release
KeyClear  in  1  debounced level, zero the count
BCD1_in  in  4  live tens digit from the counter
BCD0_in  in  4  live units digit from the counter
CountEnable  out  1  one-cycle tick to the counter's Enable
CountClear  out  1  to the counter's active-high Reset
DispBCD1  out  4  tens digit to display
DispBCD0  out  4  units digit to display
Running  out  1  high in RUN or LAP
LapActive  out  1  high in LAP

Behaviour:
Reset values:
- state=IDLE, prescaler=0, key history regs=0, lap latch=0.
- CountEnable=0, CountClear=1, DispBCD1/DispBCD0=0, Running=0, LapActive=0.
- CountClear deasserts on the first edge with Reset=1, unless a clear is requested that cycle.

Keys:
- Each key is registered once; an event is a rising edge (cur=1, prev=0).
- A key held high gives exactly one event.
- Priority when events coincide: Clear > Start > Lap. Lower-priority events in the same cycle are dropped.

FSM:
- IDLE: Start -> RUN. Clear -> IDLE with a one-cycle CountClear pulse. Lap ignored.
- RUN: Start -> PAUSE. Lap -> LAP and captures BCD1_in/BCD0_in into the lap latch. Clear ignored.
- LAP: Lap -> RUN (display goes live again). Start -> PAUSE (display goes live). Clear ignored. The count keeps advancing.
- PAUSE: Start -> RUN. Clear -> IDLE with a CountClear pulse and prescaler=0. Lap ignored.

Prescaler:
- Increments only in RUN or LAP.
- Holds its value in PAUSE, so the sub-second fraction is preserved.
- Zeroed on Reset and on Clear.
- When prescaler==TICK_DIV-1 in RUN/LAP, it wraps to 0 and CountEnable=1 for exactly that one registered cycle. Otherwise CountEnable=0.
- A state change away from RUN/LAP in the tick cycle still issues that tick.

Lap capture coinciding with a tick:
- The latch takes the pre-increment inputs.

Display:
- Registered, one-cycle latency.
- In LAP: lap latch. Otherwise: BCD1_in/BCD0_in.

Status outputs:
- Running and LapActive are registered decodes of the next state.

Wrap:
- Without the optional feature, the count 99 -> 00 is left to the counter and the controller keeps ticking.

Reset mid-operation:
- Reset overrides everything: returns to IDLE and clears the counter as above.

Optional Feature:
STOPWATCH_LIMIT_EN
- Defined: when a tick would fire in RUN/LAP while BCD1_in==9 and BCD0_in==9:
  - CountEnable is suppressed.
  - The prescaler goes to 0 and the state goes to PAUSE.
  - The display goes live and shows 99.
  - An extra output port LimitHit (1 bit, reset 0) is set. It clears on Clear or Reset.
  - Start from PAUSE while LimitHit=1 is ignored.
- Undefined: no LimitHit port; counting wraps 99 -> 00.

Decomposition:
Package stopwatch_pkg:
- State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3.
- Digit width constant BCD_W=4 and BCD_MAX=4'd9.

Sub-module tick_gen (parameters TICK_DIV/TICK_W):
- Inputs: run, clr. Output: tick. Holds the prescaler.

Top level:
- FSM, key edge detection, lap latch and display mux.

Test Plan:
1. TICK_DIV=4. Hold Reset=0 for 2 cycles, release -> CountClear=1 during reset and 0 on the first cycle after; all other outputs 0; state IDLE.
2. TICK_DIV=4. Start pulse -> Running=1 next cycle; CountEnable high every 4th cycle; a bench BCDcount advances 00 -> 01 -> 02.
3. Pause after the prescaler reaches 2, wait 20 cycles, Start again -> zero ticks while paused; next tick exactly 2 cycles after resume (prescaler value 2 carries over).
4. Running at 05: Lap -> DispBCD frozen at 05 while the counter reaches 08; Lap again -> display 08 next cycle.
5. Clear in RUN -> ignored. Start+Clear same cycle in PAUSE -> Clear wins: IDLE, one-cycle CountClear, display 00 two cycles later.
6. STOPWATCH_LIMIT_EN defined, counter at 99, tick due -> no CountEnable, state PAUSE, LimitHit=1, display 99; Start ignored; Clear -> LimitHit=0, count 00.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch controller: run-state encoding,
// BCD digit width/limit and a small state-decode helper.
// Optional feature macro used by the controller: STOPWATCH_LIMIT_EN.
package stopwatch_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Run-state encoding kept as plain constants for legacy compatibility.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    // True in the states where the count advances.
    function automatic logic is_counting(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_LAP);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler for the stopwatch: counts clock cycles while running and
// emits a one-cycle registered tick every TICK_DIV cycles.
// 'stop' suppresses the tick that would fire this cycle (the prescaler
// still wraps); 'due' flags that the wrap happens on this edge.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic clr,
    input  logic stop,
    output logic due,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    assign due = run && (count == LAST);

    // Prescaler count and registered tick; clear wins, PAUSE/IDLE hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (due) begin
                count <= '0;
                tick  <= ~stop;
            end else if (run) begin
                count <= count + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller for a two-digit BCD seconds counter.
// Detects key edges, runs the IDLE/RUN/PAUSE/LAP state machine, drives the
// counter's Enable/Clear and selects live or lap-frozen digits for display.
// Optional macro STOPWATCH_LIMIT_EN: stop at 99 and raise LimitHit instead
// of wrapping to 00.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             KeyStart,
    input  logic             KeyLap,
    input  logic             KeyClear,
    input  logic [BCD_W-1:0] BCD1_in,
    input  logic [BCD_W-1:0] BCD0_in,
    output logic             CountEnable,
    output logic             CountClear,
    output logic [BCD_W-1:0] DispBCD1,
    output logic [BCD_W-1:0] DispBCD0,
    output logic             Running,
`ifdef STOPWATCH_LIMIT_EN
    output logic             LapActive,
    output logic             LimitHit
`else
    output logic             LapActive
`endif
);

    // Key history, bit order {clear, lap, start}.
    logic [2:0] key_cur;
    logic [2:0] key_prev;
    logic [2:0] key_ev;
    logic       ev_clear;
    logic       ev_start;
    logic       ev_lap;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       capture;
    logic       do_clear;
    logic       run;
    logic       tick_due;
    logic       limit_fire;
    logic       limit_hit;

    logic [2*BCD_W-1:0] lap_latch;

    assign key_ev   = key_cur & ~key_prev;
    // Clear > Start > Lap; lower-priority coincident events are dropped.
    assign ev_clear = key_ev[2];
    assign ev_start = key_ev[0] & ~key_ev[2];
    assign ev_lap   = key_ev[1] & ~key_ev[0] & ~key_ev[2];

    assign run = is_counting(state);

`ifdef STOPWATCH_LIMIT_EN
    assign limit_fire = tick_due && (BCD1_in == BCD_MAX) && (BCD0_in == BCD_MAX);
    assign LimitHit   = limit_hit;

    // Limit flag: set when the count would pass 99, cleared by Clear.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            limit_hit <= 1'b0;
        end else if (do_clear) begin
            limit_hit <= 1'b0;
        end else if (limit_fire) begin
            limit_hit <= 1'b1;
        end
    end
`else
    assign limit_fire = 1'b0;
    assign limit_hit  = 1'b0;
`endif

    // Register each key once and keep the previous sample for edge detect.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            key_cur  <= '0;
            key_prev <= '0;
        end else begin
            key_cur  <= {KeyClear, KeyLap, KeyStart};
            key_prev <= key_cur;
        end
    end

    // Next-state decode; a limit hit overrides any key action.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        do_clear   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ev_clear) begin
                    do_clear = 1'b1;
                end else if (ev_start) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ev_start) begin
                    next_state = ST_PAUSE;
                end else if (ev_lap) begin
                    next_state = ST_LAP;
                    capture    = 1'b1;
                end
            end
            ST_LAP: begin
                if (ev_start) begin
                    next_state = ST_PAUSE;
                end else if (ev_lap) begin
                    next_state = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (ev_clear) begin
                    do_clear   = 1'b1;
                    next_state = ST_IDLE;
                end else if (ev_start && !limit_hit) begin
                    next_state = ST_RUN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (limit_fire) begin
            next_state = ST_PAUSE;
            capture    = 1'b0;
        end
    end

    // State, counter clear, status flags, lap latch and display register.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            CountClear <= 1'b1;
            Running    <= 1'b0;
            LapActive  <= 1'b0;
            lap_latch  <= '0;
            DispBCD1   <= '0;
            DispBCD0   <= '0;
        end else begin
            state      <= next_state;
            CountClear <= do_clear;
            Running    <= is_counting(next_state);
            LapActive  <= (next_state == ST_LAP);
            if (capture) begin
                lap_latch <= {BCD1_in, BCD0_in};
            end
            // Entering LAP shows the live value, which equals the capture.
            if ((state == ST_LAP) && (next_state == ST_LAP)) begin
                {DispBCD1, DispBCD0} <= lap_latch;
            end else begin
                {DispBCD1, DispBCD0} <= {BCD1_in, BCD0_in};
            end
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clock   (Clock),
        .reset_n (Reset),
        .run     (run),
        .clr     (do_clear),
        .stop    (limit_fire),
        .due     (tick_due),
        .tick    (CountEnable)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4. A behavioural
// two-digit BCD counter driven by CountEnable/CountClear feeds the digits.
module tb_stopwatch_ctrl;

    logic       Clock;
    logic       Reset;
    logic       KeyStart;
    logic       KeyLap;
    logic       KeyClear;
    logic [3:0] BCD1_in;
    logic [3:0] BCD0_in;
    logic       CountEnable;
    logic       CountClear;
    logic [3:0] DispBCD1;
    logic [3:0] DispBCD0;
    logic       Running;
    logic       LapActive;
`ifdef STOPWATCH_LIMIT_EN
    logic       LimitHit;
`endif

    int n_cmp;
    int n_fail;

    // Bench BCD counter (tens m1, units m0) with a load port.
    logic [3:0] m1;
    logic [3:0] m0;
    logic       load_en;
    logic [3:0] load1;
    logic [3:0] load0;

    assign BCD1_in = m1;
    assign BCD0_in = m0;

    stopwatch_ctrl #(
        .TICK_DIV (4),
        .TICK_W   (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .KeyStart    (KeyStart),
        .KeyLap      (KeyLap),
        .KeyClear    (KeyClear),
        .BCD1_in     (BCD1_in),
        .BCD0_in     (BCD0_in),
        .CountEnable (CountEnable),
        .CountClear  (CountClear),
        .DispBCD1    (DispBCD1),
        .DispBCD0    (DispBCD0),
        .Running     (Running),
`ifdef STOPWATCH_LIMIT_EN
        .LapActive   (LapActive),
        .LimitHit    (LimitHit)
`else
        .LapActive   (LapActive)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (CountClear === 1'b1) begin
            m1 <= 4'd0;
            m0 <= 4'd0;
        end else if (load_en) begin
            m1 <= load1;
            m0 <= load0;
        end else if (CountEnable === 1'b1) begin
            if (m0 == 4'd9) begin
                m0 <= 4'd0;
                m1 <= (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
            end else begin
                m0 <= m0 + 4'd1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        step(2);
        n_cmp++; if (CountClear !== 1'b1) begin n_fail++; $display("FAIL rst_clear got=%b exp=1", CountClear); end
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL rst_enable got=%b exp=0", CountEnable); end
        n_cmp++; if ({Running, LapActive} !== 2'b00) begin n_fail++; $display("FAIL rst_status got=%b exp=00", {Running, LapActive}); end
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h00) begin n_fail++; $display("FAIL rst_disp got=%h exp=00", {DispBCD1, DispBCD0}); end
        Reset = 1'b1;
        step(1);
        n_cmp++; if (CountClear !== 1'b0) begin n_fail++; $display("FAIL rst_release_clear got=%b exp=0", CountClear); end
        n_cmp++; if ({Running, LapActive, CountEnable} !== 3'b000) begin n_fail++; $display("FAIL rst_release_status got=%b exp=000", {Running, LapActive, CountEnable}); end
    endtask

    task automatic test_run;
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL run_running got=%b exp=1", Running); end
        step(3);
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL run_pre_tick got=%b exp=0", CountEnable); end
        step(1);
        n_cmp++; if (CountEnable !== 1'b1) begin n_fail++; $display("FAIL run_tick1 got=%b exp=1", CountEnable); end
        step(1);
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL run_tick1_width got=%b exp=0", CountEnable); end
        step(1);
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h01) begin n_fail++; $display("FAIL run_disp01 got=%h exp=01", {DispBCD1, DispBCD0}); end
        step(2);
        n_cmp++; if (CountEnable !== 1'b1) begin n_fail++; $display("FAIL run_tick2 got=%b exp=1", CountEnable); end
    endtask

    task automatic test_pause;
        int ticks;
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL pause_running got=%b exp=0", Running); end
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h02) begin n_fail++; $display("FAIL pause_disp02 got=%h exp=02", {DispBCD1, DispBCD0}); end
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (CountEnable === 1'b1) ticks++;
        end
        n_cmp++; if (ticks !== 0) begin n_fail++; $display("FAIL pause_no_ticks got=%0d exp=0", ticks); end
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if ({Running, CountEnable} !== 2'b10) begin n_fail++; $display("FAIL resume_state got=%b exp=10", {Running, CountEnable}); end
        step(1);
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL resume_early got=%b exp=0", CountEnable); end
        step(1);
        n_cmp++; if (CountEnable !== 1'b1) begin n_fail++; $display("FAIL resume_tick got=%b exp=1", CountEnable); end
    endtask

    task automatic test_lap;
        int guard;
        int bad;
        guard = 0;
        while ({m1, m0} != 8'h05 && guard < 100) begin step(1); guard++; end
        n_cmp++; if (guard >= 100) begin n_fail++; $display("FAIL lap_wait05 got=%h exp=05", {m1, m0}); end
        KeyLap = 1'b1; step(1); KeyLap = 1'b0;
        step(1);
        n_cmp++; if ({Running, LapActive} !== 2'b11) begin n_fail++; $display("FAIL lap_enter got=%b exp=11", {Running, LapActive}); end
        bad = 0; guard = 0;
        while ({m1, m0} != 8'h08 && guard < 100) begin
            step(1); guard++;
            if ({DispBCD1, DispBCD0} !== 8'h05) bad++;
        end
        n_cmp++; if (guard >= 100) begin n_fail++; $display("FAIL lap_wait08 got=%h exp=08", {m1, m0}); end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL lap_frozen got=%0d_deviations exp=0", bad); end
        KeyLap = 1'b1; step(1); KeyLap = 1'b0;
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h05) begin n_fail++; $display("FAIL lap_still_frozen got=%h exp=05", {DispBCD1, DispBCD0}); end
        step(1);
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h08) begin n_fail++; $display("FAIL lap_release_disp got=%h exp=08", {DispBCD1, DispBCD0}); end
        n_cmp++; if ({Running, LapActive} !== 2'b10) begin n_fail++; $display("FAIL lap_release_status got=%b exp=10", {Running, LapActive}); end
    endtask

    task automatic test_clear;
        KeyClear = 1'b1; step(1); KeyClear = 1'b0;
        step(1);
        n_cmp++; if ({CountClear, Running} !== 2'b01) begin n_fail++; $display("FAIL clear_in_run got=%b exp=01", {CountClear, Running}); end
        step(1);
        n_cmp++; if (CountClear !== 1'b0) begin n_fail++; $display("FAIL clear_in_run_late got=%b exp=0", CountClear); end
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if (Running !== 1'b0) begin n_fail++; $display("FAIL clear_pause got=%b exp=0", Running); end
        KeyStart = 1'b1; KeyClear = 1'b1; step(1); KeyStart = 1'b0; KeyClear = 1'b0;
        step(1);
        n_cmp++; if ({CountClear, Running, LapActive} !== 3'b100) begin n_fail++; $display("FAIL clear_wins got=%b exp=100", {CountClear, Running, LapActive}); end
        step(1);
        n_cmp++; if ({CountClear, Running} !== 2'b00) begin n_fail++; $display("FAIL clear_pulse_width got=%b exp=00", {CountClear, Running}); end
        step(1);
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h00) begin n_fail++; $display("FAIL clear_disp got=%h exp=00", {DispBCD1, DispBCD0}); end
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL clear_idle_enable got=%b exp=0", CountEnable); end
    endtask

    task automatic test_back_to_back;
        KeyStart = 1'b1;
        step(2);
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL hold_start got=%b exp=1", Running); end
        step(4);
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL hold_single_event got=%b exp=1", Running); end
        KeyStart = 1'b0;
        step(1);
        Reset = 1'b0;
        step(1);
        n_cmp++; if ({Running, CountClear, CountEnable} !== 3'b010) begin n_fail++; $display("FAIL midrst got=%b exp=010", {Running, CountClear, CountEnable}); end
        Reset = 1'b1;
        step(1);
        n_cmp++; if (CountClear !== 1'b0) begin n_fail++; $display("FAIL midrst_release got=%b exp=0", CountClear); end
    endtask

    task automatic test_wrap;
        load1 = 4'd9; load0 = 4'd9; load_en = 1'b1;
        step(1);
        load_en = 1'b0;
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL at99_running got=%b exp=1", Running); end
        step(3);
        n_cmp++; if (CountEnable !== 1'b0) begin n_fail++; $display("FAIL at99_pre_tick got=%b exp=0", CountEnable); end
        step(1);
`ifdef STOPWATCH_LIMIT_EN
        n_cmp++; if ({CountEnable, Running, LimitHit} !== 3'b001) begin n_fail++; $display("FAIL limit_hit got=%b exp=001", {CountEnable, Running, LimitHit}); end
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h99) begin n_fail++; $display("FAIL limit_disp got=%h exp=99", {DispBCD1, DispBCD0}); end
        KeyStart = 1'b1; step(1); KeyStart = 1'b0;
        step(1);
        n_cmp++; if ({Running, CountEnable} !== 2'b00) begin n_fail++; $display("FAIL limit_start_ignored got=%b exp=00", {Running, CountEnable}); end
        KeyClear = 1'b1; step(1); KeyClear = 1'b0;
        step(1);
        n_cmp++; if ({CountClear, LimitHit} !== 2'b10) begin n_fail++; $display("FAIL limit_clear got=%b exp=10", {CountClear, LimitHit}); end
        step(2);
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h00) begin n_fail++; $display("FAIL limit_clear_disp got=%h exp=00", {DispBCD1, DispBCD0}); end
`else
        n_cmp++; if (CountEnable !== 1'b1) begin n_fail++; $display("FAIL wrap_tick got=%b exp=1", CountEnable); end
        step(2);
        n_cmp++; if ({DispBCD1, DispBCD0} !== 8'h00) begin n_fail++; $display("FAIL wrap_disp got=%h exp=00", {DispBCD1, DispBCD0}); end
        n_cmp++; if (Running !== 1'b1) begin n_fail++; $display("FAIL wrap_running got=%b exp=1", Running); end
`endif
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        KeyStart = 1'b0;
        KeyLap   = 1'b0;
        KeyClear = 1'b0;
        load_en  = 1'b0;
        load1    = 4'd0;
        load0    = 4'd0;
        test_reset();
        test_run();
        test_pause();
        test_lap();
        test_clear();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
